// File: rtl/input_debouncer_pkg.sv
// Shared types and channel counts for the input debouncer.
package input_debouncer_pkg;

  typedef enum logic [0:0] {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  localparam int SW_CH  = 32;
  localparam int BTN_CH = 4;
  localparam int N_CH   = SW_CH + BTN_CH;

endpackage

// File: rtl/input_debouncer_debounce_cell.sv
// One debounced channel: synchroniser chain, STABLE/PENDING FSM and tick counter.
module debounce_cell
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_out
);

  localparam int            NW     = $clog2(STABLE_TICKS + 1);
  localparam logic [NW-1:0] N_LAST = NW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  db_state_e              state_q, state_d;
  logic [NW-1:0]          n_q, n_d;
  logic                   out_q, out_d;
  logic                   sync;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign o_out = out_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    out_d   = out_q;
    case (state_q)
      DB_STABLE: begin
        n_d = '0;
        if (sync != out_q) state_d = DB_PENDING;
      end
      DB_PENDING: begin
        // Any return to the current output value throws away the accumulated count.
        if (sync == out_q) begin
          state_d = DB_STABLE;
          n_d     = '0;
        end else if (i_tick) begin
          if (n_q == N_LAST) begin
            out_d   = sync;
            state_d = DB_STABLE;
            n_d     = '0;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
      default: begin
        state_d = DB_STABLE;
        n_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      state_q <= DB_STABLE;
      n_q     <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_raw};
      state_q <= state_d;
      n_q     <= n_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Switch/button conditioning: polarity fix, shared prescaler, 36 debounce cells.
// Optional press pulses are built only when DEBOUNCE_PRESS_PULSE_EN is defined.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_CYCLES    = 50_000,
  parameter int STABLE_TICKS   = 10,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_press
);

  localparam int            CW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic          BTN_INV  = (BTN_ACTIVE_LOW != 0);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick;
  logic [N_CH-1:0] raw_ch;
  logic [N_CH-1:0] clean_ch;

  // Free-running: input activity never re-phases the tick.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign raw_ch = {i_btn_raw ^ {BTN_CH{BTN_INV}}, i_sw_raw};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (raw_ch[gi]),
      .i_tick (tick),
      .o_out  (clean_ch[gi])
    );
  end

  assign o_io_sw  = clean_ch[SW_CH-1:0];
  assign o_io_btn = clean_ch[N_CH-1:SW_CH];

`ifdef DEBOUNCE_PRESS_PULSE_EN
  logic [BTN_CH-1:0] btn_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) btn_prev_q <= '0;
    else          btn_prev_q <= o_io_btn;
  end

  // Both operands are flops, so the pulse shares the rising edge of o_io_btn.
  assign o_btn_press = o_io_btn & ~btn_prev_q;
`else
  assign o_btn_press = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (TICK_CYCLES=4, STABLE_TICKS=3, SYNC_STAGES=2).
module tb_input_debouncer;

`ifdef DEBOUNCE_PRESS_PULSE_EN
  localparam logic PULSE_EN = 1'b1;
`else
  localparam logic PULSE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] sw;
    logic [3:0]  btn;
    int          lo;
    int          hi;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] sw_raw  = '0;
  logic [3:0]  btn_raw = 4'hF;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_press;

  int   errors = 0;
  int   checks = 0;
  int   press_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES   (2),
    .TICK_CYCLES   (4),
    .STABLE_TICKS  (3),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sw_raw   (sw_raw),
    .i_btn_raw  (btn_raw),
    .o_io_sw    (o_io_sw),
    .o_io_btn   (o_io_btn),
    .o_btn_press(o_btn_press)
  );

  always @(negedge clk) if (o_btn_press[0] === 1'b1) press_cnt++;

  // Waits for any output change. Latency counts clocks from the first edge
  // that samples the new raw value (stimulus is driven on the falling edge).
  task automatic wait_change(input int budget, output int lat, output logic ok);
    logic [35:0] prev;
    prev = {o_io_btn, o_io_sw};
    ok   = 1'b0;
    lat  = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if ({o_io_btn, o_io_sw} !== prev) begin
        lat = k - 1;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    logic ok;
    sw_raw  = 32'hFFFF_FFFF;
    btn_raw = 4'hF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_io_sw !== 32'h0) begin errors++; $display("FAIL reset_sw: got %h want %h", o_io_sw, 32'h0); end
    checks++;
    if (o_io_btn !== 4'h0) begin errors++; $display("FAIL reset_btn: got %h want %h", o_io_btn, 4'h0); end
    checks++;
    if (o_btn_press !== 4'h0) begin errors++; $display("FAIL reset_press: got %h want %h", o_btn_press, 4'h0); end
    exp_q.push_back('{sw: 32'hFFFF_FFFF, btn: 4'h0, lo: 11, hi: 14});
    rst_n = 1'b1;
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL reset_release_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL reset_release_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
  endtask

  task automatic test_clean_edge();
    exp_t e;
    int   lat;
    logic ok;
    sw_raw  = 32'h0;
    btn_raw = 4'hF;
    do_reset();
    repeat (3) @(negedge clk);
    sw_raw[5] = 1'b1;
    exp_q.push_back('{sw: 32'h0000_0020, btn: 4'h0, lo: 11, hi: 14});
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL clean_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL clean_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
    repeat (20) @(negedge clk);
    checks++;
    if (o_io_sw !== 32'h0000_0020) begin errors++; $display("FAIL clean_hold: got %h want %h", o_io_sw, 32'h0000_0020); end
  endtask

  task automatic test_bounce();
    exp_t e;
    int   lat;
    int   flips;
    logic ok;
    logic prev7;
    flips = 0;
    prev7 = o_io_sw[7];
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (o_io_sw[7] !== prev7) begin flips++; prev7 = o_io_sw[7]; end
      if (c % 3 == 0) sw_raw[7] = ~sw_raw[7];
    end
    checks++;
    if (flips != 0) begin errors++; $display("FAIL bounce_no_flip: got %0d flips want 0", flips); end
    @(negedge clk);
    sw_raw[7] = 1'b1;
    exp_q.push_back('{sw: 32'h0000_00A0, btn: 4'h0, lo: 11, hi: 14});
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL bounce_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL bounce_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
    repeat (20) @(negedge clk);
    checks++;
    if (o_io_sw !== 32'h0000_00A0) begin errors++; $display("FAIL bounce_single_rise: got %h want %h", o_io_sw, 32'h0000_00A0); end
  endtask

  task automatic test_button_press();
    exp_t e;
    int   lat;
    int   p0;
    logic ok;
    p0 = press_cnt;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    exp_q.push_back('{sw: 32'h0000_00A0, btn: 4'h1, lo: 11, hi: 14});
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL press_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL press_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
    checks++;
    if (o_btn_press !== {3'b000, PULSE_EN})
      begin errors++; $display("FAIL press_pulse_on_rise: got %h want %h", o_btn_press, {3'b000, PULSE_EN}); end
    @(negedge clk);
    checks++;
    if (o_btn_press !== 4'h0) begin errors++; $display("FAIL press_pulse_width: got %h want %h", o_btn_press, 4'h0); end
    repeat (20 - lat - 3) @(negedge clk);
    btn_raw[0] = 1'b1;
    exp_q.push_back('{sw: 32'h0000_00A0, btn: 4'h0, lo: 11, hi: 14});
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL release_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL release_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
    repeat (4) @(negedge clk);
    checks++;
    if (press_cnt - p0 != (PULSE_EN ? 1 : 0))
      begin errors++; $display("FAIL press_pulse_count: got %0d want %0d", press_cnt - p0, PULSE_EN ? 1 : 0); end
  endtask

  task automatic test_reset_mid_pending();
    exp_t e;
    int   lat;
    logic ok;
    @(negedge clk);
    sw_raw[0] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (o_io_sw[0] !== 1'b0) begin errors++; $display("FAIL midpend_before_reset: got %b want %b", o_io_sw[0], 1'b0); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_io_sw !== 32'h0) begin errors++; $display("FAIL midpend_async_clear: got %h want %h", o_io_sw, 32'h0); end
    repeat (2) @(negedge clk);
    exp_q.push_back('{sw: 32'h0000_00A1, btn: 4'h0, lo: 11, hi: 14});
    rst_n = 1'b1;
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL midpend_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL midpend_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   lat;
    logic ok;
    repeat (3) @(negedge clk);
    sw_raw  = ~sw_raw;
    btn_raw = 4'h0;
    exp_q.push_back('{sw: ~32'h0000_00A1, btn: 4'hF, lo: 11, hi: 14});
    wait_change(30, lat, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o_io_sw !== e.sw || o_io_btn !== e.btn)
      begin errors++; $display("FAIL simul_value: got sw=%h btn=%h want sw=%h btn=%h", o_io_sw, o_io_btn, e.sw, e.btn); end
    checks++;
    if (!ok || lat < e.lo || lat > e.hi)
      begin errors++; $display("FAIL simul_latency: got %0d want %0d..%0d", lat, e.lo, e.hi); end
    checks++;
    if (o_btn_press !== {4{PULSE_EN}})
      begin errors++; $display("FAIL simul_press: got %h want %h", o_btn_press, {4{PULSE_EN}}); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_button_press();
    test_reset_mid_pending();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Front-end conditioning stage that sits directly upstream of the processor's memory-mapped input ports: it takes the raw board switches and push-buttons, synchronises them into the core clock domain, debounces them, and drives the clean `i_io_sw` / `i_io_btn` values the core reads. Buttons on the board are active-low, and this block normalises them to active-high, where 1 means pressed. An optional press-pulse output gives software-independent edge events.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth, ≥2.
- `TICK_CYCLES`, default 50_000: prescaler period in clocks (1 ms at 50 MHz), ≥1.
- `STABLE_TICKS`, default 10: consecutive ticks a changed input must hold before the output follows, ≥1.
- `BTN_ACTIVE_LOW`, default 1: 1 means raw buttons are inverted before synchronisation.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_sw_raw`  in  32  raw switches, asynchronous to `i_clk`.
- `i_btn_raw`  in  4  raw buttons, asynchronous.
- `o_io_sw`  out  32  debounced switches, to core `i_io_sw`.
- `o_io_btn`  out  4  debounced buttons, active-high, to core `i_io_btn`.
- `o_btn_press`  out  4  one-cycle pulse per debounced press (see Configuration).

## Operation
- Handles 36 independent channels: sw[31:0] form channels 0–31, btn[3:0] form channels 32–35.
- Polarity: button raw bits are XORed with `BTN_ACTIVE_LOW` before the synchroniser. Every channel is active-high from that point on.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per channel. Its reset value is 0, which is the post-polarity "released/off" value.
- Shared prescaler: `cnt` counts 0..`TICK_CYCLES`-1 and wraps. `tick` = (`cnt` == `TICK_CYCLES`-1). The prescaler runs continuously and is not restarted by input activity.
- Per-channel FSM, states `STABLE` and `PENDING`, with a counter `n` of width $clog2(STABLE_TICKS+1):
  - `STABLE`, sync == out: hold, `n`=0.
  - `STABLE`, sync != out: go to `PENDING`, `n`=0.
  - `PENDING`, sync == out (a bounce back): go to `STABLE`, `n`=0, output unchanged.
  - `PENDING`, sync != out, `tick`, `n`==`STABLE_TICKS`-1: out <= sync, go to `STABLE`, `n`=0.
  - `PENDING`, sync != out, `tick`, otherwise: `n`++.
  - `PENDING`, sync != out, no tick: hold.
- Reset values: `o_io_sw`=0, `o_io_btn`=0, `o_btn_press`=0, prescaler 0, every FSM in `STABLE` with `n`=0. Reset mid-`PENDING` discards the pending change immediately and asynchronously.
- Simultaneous events: channels are independent. Any set of channels may flip on the same edge.

## Timing
- From raw edge to a synchronised change: `SYNC_STAGES` clocks.
- From synchronised change to output flip:
  - Minimum (`STABLE_TICKS`-1)·`TICK_CYCLES`+1 clocks.
  - Maximum `STABLE_TICKS`·`TICK_CYCLES` clocks. Where it falls in this range depends on prescaler phase.
- Any bounce back to the current output value restarts the full wait.
- Outputs are registered with no combinational path from inputs. `o_btn_press` asserts on the same edge that `o_io_btn` goes 0→1 and lasts exactly 1 clock.

## Configuration
- Macro `DEBOUNCE_PRESS_PULSE_EN`.
  - Defined: `o_btn_press[i]` = 1 for one clock when `o_io_btn[i]` rises. There is no pulse on release.
  - Undefined: `o_btn_press` is tied to 4'b0 and no edge-detect flops are built. Port list is unchanged.

## Structure
- Package `input_debouncer_pkg` holds:
  - the FSM state typedef `db_state_e` (`DB_STABLE`, `DB_PENDING`);
  - localparams `SW_CH`=32, `BTN_CH`=4, `N_CH`=36.
- Sub-module `debounce_cell`, generated `N_CH` times. It contains the synchroniser, FSM, and tick counter for one channel. It takes `tick` from the top-level prescaler.
- The top level holds the polarity XOR, the prescaler, the generate loop, and the optional press detector.

## Test plan
Bench parameters: `TICK_CYCLES`=4, `STABLE_TICKS`=3, `SYNC_STAGES`=2.
- Reset: assert `i_rst_n`=0 with `i_btn_raw`=4'hF and `i_sw_raw`=32'hFFFF_FFFF, release, then hold inputs → `o_io_sw` and `o_io_btn` are 0 during reset, and `o_io_sw` becomes 32'hFFFF_FFFF 11–14 clocks after release.
- Clean edge: `i_sw_raw[5]` 0→1 and held → `o_io_sw[5]`=1 no earlier than 11 and no later than 14 clocks after the edge. Other bits stay 0.
- Bounce: `i_sw_raw[7]` toggles every 3 clocks for 40 clocks, then settles at 1 → `o_io_sw[7]` has exactly one 0→1 transition, which occurs 11–14 clocks after settling.
- Button press: `i_btn_raw[0]` 1→0 held 20 clocks, then back to 1 → `o_io_btn[0]` rises and then falls.
  - With the macro: `o_btn_press[0]` gives a single 1-clock pulse, coincident with the rise only.
  - Without the macro: `o_btn_press` stays 0.
- Reset mid-pending: `i_sw_raw[0]` 0→1, then assert `i_rst_n` 6 clocks later → `o_io_sw[0]` stays 0. After release, the output rises 11–14 clocks later with no carried-over count.
- Simultaneous: all 32 switches and 4 buttons change on the same clock → all 36 outputs flip on the same edge.
